// File: rtl/serv_ibus_pkg.sv
// Shared types and constants for the instruction-bus responder.
package serv_ibus_pkg;

  localparam int CNT_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_e;

  // Any address bit above the word-index field means the fetch misses memory.
  function automatic logic adr_out_of_range(input logic [31:0] adr, input int aw);
    return (adr >> (aw + 2)) != 32'd0;
  endfunction

endpackage

// File: rtl/serv_ibus_ram.sv
// Instruction storage: one sync write port, one sync read port, read-before-write.
module serv_ibus_ram #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdat,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdat
);

  logic [31:0] mem [DEPTH];

  // Both ports use non-blocking updates, so a same-edge read sees the old word.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdat;
    if (re) rdat <= mem[raddr];
  end

endmodule

// File: rtl/serv_ibus_responder.sv
// Wishbone-style instruction fetch responder with fixed wait-state latency.
module serv_ibus_responder
  import serv_ibus_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic                       clk,
  input  logic                       i_rst,
  input  logic [31:0]                i_wb_adr,
  input  logic                       i_wb_cyc,
  output logic [31:0]                o_wb_rdt,
  output logic                       o_wb_ack,
  output logic                       o_wb_err,
  input  logic                       i_load_we,
  input  logic [$clog2(DEPTH)-1:0]   i_load_adr,
  input  logic [31:0]                i_load_dat
);

  localparam int AW = $clog2(DEPTH);

  state_e           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [AW-1:0]    idx_q, idx_nxt;
  logic             err_q, err_nxt;
  logic             req_err;
  logic             rd_en;
  logic [31:0]      ram_rdat;

  assign req_err = adr_out_of_range(i_wb_adr, AW);

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state <= IDLE;
      cnt   <= '0;
      idx_q <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx_q <= idx_nxt;
      err_q <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx_q;
    err_nxt   = err_q;
    case (state)
      IDLE: if (i_wb_cyc) begin
        idx_nxt   = i_wb_adr[AW+1:2];
        err_nxt   = req_err;
        cnt_nxt   = CNT_W'(LATENCY);
        state_nxt = (LATENCY == 0) ? ACK : WAIT;
      end
      WAIT: if (!i_wb_cyc) begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end else begin
        cnt_nxt = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) state_nxt = ACK;
      end
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // idx_nxt is the fresh index from IDLE or the latched one from WAIT.
  assign rd_en = !i_rst && (state != ACK) && (state_nxt == ACK) && !err_nxt;

  serv_ibus_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (i_load_we && !i_rst),
    .waddr (i_load_adr),
    .wdat  (i_load_dat),
    .re    (rd_en),
    .raddr (idx_nxt),
    .rdat  (ram_rdat)
  );

  always_comb begin
    o_wb_ack = (state == ACK);
    o_wb_err = o_wb_ack && err_q;
    o_wb_rdt = (o_wb_ack && !err_q) ? ram_rdat : 32'd0;
  end

endmodule

// File: doc/serv_ibus_responder.md
SERV_IBUS_RESPONDER -- requirements
Module: serv_ibus_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 256, meaning instruction memory size in 32-bit words; power of two, 2..4096.
REQ-002 SHALL have parameter LATENCY, default 2, meaning wait cycles inserted before ack; range 0..7.
REQ-003 SHALL derive AW = log2(DEPTH) internally as a localparam, not as a port-visible parameter.
REQ-004 SHALL run on one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  sole clock, all state updates on rising edge.
REQ-006 i_rst  input  1  synchronous active-high reset.
REQ-007 i_wb_adr  input  32  byte address of instruction fetch from the core's PC logic.
REQ-008 i_wb_cyc  input  1  fetch request, held high by initiator until ack.
REQ-009 o_wb_rdt  output  32  instruction word, valid only while o_wb_ack high.
REQ-010 o_wb_ack  output  1  single-cycle fetch completion strobe.
REQ-011 o_wb_err  output  1  out-of-range flag, qualified by o_wb_ack.
REQ-012 i_load_we  input  1  preload write enable.
REQ-013 i_load_adr  input  AW  preload word index.
REQ-014 i_load_dat  input  32  preload write data.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, ACK; reset state IDLE.
REQ-016 IDLE: i_wb_cyc=1 sampled SHALL capture word index i_wb_adr[AW+1:2] and the range flag, load the wait counter with LATENCY, then go to WAIT (LATENCY>0) or ACK (LATENCY=0).
REQ-017 WAIT: counter SHALL decrement each cycle; the transition to ACK SHALL occur when the counter reaches 1.
REQ-018 o_wb_ack SHALL be high exactly in cycle n+LATENCY+1, where n is the cycle in which IDLE sampled i_wb_cyc=1.
REQ-019 ACK SHALL last exactly one cycle, then return to IDLE unconditionally.
REQ-020 i_wb_cyc=1 in the cycle after ACK SHALL be treated as a new request (back-to-back fetch, 1 idle cycle between acks minimum).
REQ-021 i_wb_cyc dropping to 0 in WAIT SHALL abort: next state IDLE, no ack issued.
REQ-022 i_wb_adr[1:0] SHALL be ignored (no misalignment error).
REQ-023 i_wb_adr[31:AW+2] nonzero SHALL give o_wb_err=1 and o_wb_rdt=0 during the ack cycle; memory SHALL not be read.
REQ-024 In-range read data SHALL be registered from memory on the edge entering ACK.
REQ-025 o_wb_rdt and o_wb_err SHALL be 0 whenever o_wb_ack=0.
REQ-026 i_load_we SHALL write i_load_dat at i_load_adr in any state.
REQ-027 A load to the same word on the edge entering ACK SHALL return the old data (read-before-write); the new data SHALL be visible to later fetches.
REQ-028 The address SHALL be latched at request acceptance; i_wb_adr changes during WAIT SHALL not affect the returned word.

Reset
REQ-029 i_rst=1 SHALL force state IDLE, o_wb_ack=0, o_wb_err=0, o_wb_rdt=0, counter=0 on the next edge.
REQ-030 Reset mid-WAIT SHALL abort the transaction, with no ack afterwards unless a new request arrives.
REQ-031 Memory contents SHALL not be cleared by reset.
REQ-032 i_load_we SHALL be ignored during reset.

Structure
REQ-033 Package serv_ibus_pkg SHALL hold the FSM state enum and the counter width constant (3 bits).
REQ-034 Storage SHALL be a sub-module serv_ibus_ram, with one synchronous write port and one synchronous read port and read-before-write behaviour; the FSM and range check SHALL remain in the top module.

Verification
REQ-035 LATENCY=2: preload word 5=0xDEADBEEF; cyc=1 with adr=0x14 at cycle 0 -> ack only in cycle 3, rdt=0xDEADBEEF, err=0.
REQ-036 LATENCY=0: cyc held high across two fetches with adr 0x0 then 0x4 -> acks in cycles 1 and 3, with correct preloaded words.
REQ-037 DEPTH=256: adr=0x400 -> ack with err=1 and rdt=0x00000000.
REQ-038 LATENCY=3: cyc drops in cycle 2 -> no ack ever; next request at adr 0x8 acks 4 cycles after acceptance.
REQ-039 i_rst pulsed in WAIT -> ack, err and rdt stay 0; FSM is IDLE next cycle.
REQ-040 Load 0x13 to word 2 on the edge entering ACK for a fetch of adr 0x8 -> old value returned; a refetch returns 0x00000013.
